// File: rtl/ram_tdp_bist_ctrl_pkg.sv
// Shared types, default sizing and the test-pattern function for the
// true-dual-port RAM BIST controller.
package ram_tdp_bist_pkg;

    localparam int DEF_AW       = 9;
    localparam int DEF_DW       = 16;
    localparam int DEF_READ_LAT = 2;
    localparam int ERR_W        = 11;
    localparam int PAT_W        = 64;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        XREAD,
        DRAIN,
        DONE
    } state_t;

    // Write data and expected read data are the seed with the word address folded in.
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                                 input logic [PAT_W-1:0] x);
        return seed ^ x;
    endfunction

endpackage

// File: rtl/ram_tdp_bist_ctrl_if.sv
// Control/status and dual-port RAM bus of the BIST controller; the controller
// is the master, the RAM plus whoever starts a run is the slave.
interface ram_tdp_bist_ctrl_if
    import ram_tdp_bist_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic             start;
    logic [DW-1:0]    seed;
    logic             weA;
    logic             weB;
    logic             reA;
    logic             reB;
    logic [AW-1:0]    addrA;
    logic [AW-1:0]    addrB;
    logic [DW-1:0]    dinA;
    logic [DW-1:0]    dinB;
    logic [DW-1:0]    doutA;
    logic [DW-1:0]    doutB;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [AW-1:0]    fail_addr;
    logic             fail_port;

    modport master (
        input  start, seed, doutA, doutB,
        output weA, weB, reA, reB, addrA, addrB, dinA, dinB,
        output busy, done, pass, err_cnt, fail_addr, fail_port
    );

    modport slave (
        output start, seed, doutA, doutB,
        input  weA, weB, reA, reB, addrA, addrB, dinA, dinB,
        input  busy, done, pass, err_cnt, fail_addr, fail_port
    );

endinterface

// File: rtl/ram_tdp_bist_ctrl_rd_check_pipe.sv
// Delay line that carries each read's address and expected word until the RAM
// returns the data, then flags a mismatch (unknown bits count as a mismatch).
module rd_check_pipe
    import ram_tdp_bist_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int LAT = DEF_READ_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_exp,
    input  logic [DW-1:0] i_dout,
    output logic          o_mismatch,
    output logic [AW-1:0] o_addr
);

    logic          r_valid [LAT];
    logic [AW-1:0] r_addr  [LAT];
    logic [DW-1:0] r_exp   [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_exp[i]   <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            r_exp[0]   <= i_exp;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
                r_exp[i]   <= r_exp[i-1];
            end
        end
    end

    // Case inequality so that X/Z read data is reported rather than masked.
    assign o_mismatch = r_valid[LAT-1] && (i_dout !== r_exp[LAT-1]);
    assign o_addr     = r_addr[LAT-1];

endmodule

// File: rtl/ram_tdp_bist_ctrl.sv
// BIST controller for a true-dual-port RAM: write both halves in parallel,
// read them back straight and crossed, and report pass/err_cnt/first failure.
module ram_tdp_bist_ctrl
    import ram_tdp_bist_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                clk,
    input  logic                rst,
    ram_tdp_bist_ctrl_if.master bus
);

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_cnt;
    logic [DW-1:0]    r_seed;
    logic [ERR_W-1:0] r_errCnt;
    logic [AW-1:0]    r_failAddr;
    logic             r_failPort;
    logic             r_failSeen;
    logic             r_pass;

    logic             w_accept;
    logic [AW-1:0]    w_lowAddr;
    logic [AW-1:0]    w_highAddr;
    logic             w_weA, w_weB, w_reA, w_reB;
    logic [AW-1:0]    w_addrA, w_addrB;
    logic [DW-1:0]    w_dinA, w_dinB;
    logic [DW-1:0]    w_expA, w_expB;
    logic             w_misA, w_misB;
    logic [AW-1:0]    w_misAddrA, w_misAddrB;

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_lowAddr  = AW'(r_cnt);
    assign w_highAddr = w_lowAddr | AW'(256);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= (w_nextState != r_state) ? 8'd0 : 8'(r_cnt + 8'd1);
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.start)                   w_nextState = WRITE;
            WRITE:   if (r_cnt == 8'hFF)              w_nextState = READ;
            READ:    if (r_cnt == 8'hFF)              w_nextState = XREAD;
            XREAD:   if (r_cnt == 8'hFF)              w_nextState = DRAIN;
            DRAIN:   if (r_cnt == 8'(READ_LAT - 1))   w_nextState = DONE;
            DONE:                                     w_nextState = IDLE;
            default:                                  w_nextState = IDLE;
        endcase
    end

    // Port A always owns the low half and port B the high half, except in
    // XREAD where they swap so each word is also read through the other port.
    always_comb begin
        w_weA   = 1'b0;
        w_weB   = 1'b0;
        w_reA   = 1'b0;
        w_reB   = 1'b0;
        w_addrA = '0;
        w_addrB = '0;
        w_dinA  = '0;
        w_dinB  = '0;
        unique case (r_state)
            WRITE: begin
                w_weA   = 1'b1;
                w_weB   = 1'b1;
                w_addrA = w_lowAddr;
                w_addrB = w_highAddr;
                w_dinA  = DW'(pattern(PAT_W'(r_seed), PAT_W'(w_lowAddr)));
                w_dinB  = DW'(pattern(PAT_W'(r_seed), PAT_W'(w_highAddr)));
            end
            READ: begin
                w_reA   = 1'b1;
                w_reB   = 1'b1;
                w_addrA = w_lowAddr;
                w_addrB = w_highAddr;
            end
            XREAD: begin
                w_reA   = 1'b1;
                w_reB   = 1'b1;
                w_addrA = w_highAddr;
                w_addrB = w_lowAddr;
            end
            default: ;
        endcase
    end

    assign w_expA = DW'(pattern(PAT_W'(r_seed), PAT_W'(w_addrA)));
    assign w_expB = DW'(pattern(PAT_W'(r_seed), PAT_W'(w_addrB)));

    rd_check_pipe #(.AW(AW), .DW(DW), .LAT(READ_LAT)) u_checkA (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_reA),
        .i_addr     (w_addrA),
        .i_exp      (w_expA),
        .i_dout     (bus.doutA),
        .o_mismatch (w_misA),
        .o_addr     (w_misAddrA)
    );

    rd_check_pipe #(.AW(AW), .DW(DW), .LAT(READ_LAT)) u_checkB (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_reB),
        .i_addr     (w_addrB),
        .i_exp      (w_expB),
        .i_dout     (bus.doutB),
        .o_mismatch (w_misB),
        .o_addr     (w_misAddrB)
    );

    // Result registers; only the first failing read is latched, A before B.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed     <= '0;
            r_errCnt   <= '0;
            r_failAddr <= '0;
            r_failPort <= 1'b0;
            r_failSeen <= 1'b0;
            r_pass     <= 1'b0;
        end else if (w_accept) begin
            r_seed     <= bus.seed;
            r_errCnt   <= '0;
            r_failAddr <= '0;
            r_failPort <= 1'b0;
            r_failSeen <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_errCnt <= r_errCnt + ERR_W'(w_misA) + ERR_W'(w_misB);
            if (!r_failSeen && (w_misA || w_misB)) begin
                r_failSeen <= 1'b1;
                r_failAddr <= w_misA ? w_misAddrA : w_misAddrB;
                r_failPort <= !w_misA;
            end
            if (r_state == DONE) begin
                r_pass <= (r_errCnt == '0);
            end
        end
    end

    assign bus.weA       = w_weA;
    assign bus.weB       = w_weB;
    assign bus.reA       = w_reA;
    assign bus.reB       = w_reB;
    assign bus.addrA     = w_addrA;
    assign bus.addrB     = w_addrB;
    assign bus.dinA      = w_dinA;
    assign bus.dinB      = w_dinB;
    assign bus.busy      = (r_state == WRITE) || (r_state == READ) ||
                           (r_state == XREAD) || (r_state == DRAIN);
    assign bus.done      = (r_state == DONE);
    assign bus.pass      = r_pass || ((r_state == DONE) && (r_errCnt == '0));
    assign bus.err_cnt   = r_errCnt;
    assign bus.fail_addr = r_failAddr;
    assign bus.fail_port = r_failPort;

endmodule

// File: tb/tb_ram_tdp_bist_ctrl.sv
// Directed bench for ram_tdp_bist_ctrl against a two-register true-DP RAM
// model with an optional stuck-at-1 bit on word 0x010.
module tb_ram_tdp_bist_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   testCount   = 0;
    int   failCount   = 0;
    int   monViol     = 0;
    int   donePulses  = 0;
    logic stuckEn     = 1'b0;

    always #5 clk = ~clk;

    ram_tdp_bist_ctrl_if #(.AW(9), .DW(16)) bus ();

    ram_tdp_bist_ctrl #(.AW(9), .DW(16), .READ_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [512];
    logic [8:0]  rAddrA, rAddrB;
    logic        rValA, rValB;

    function automatic logic [15:0] readWord(input logic [8:0] a);
        logic [15:0] w;
        w = mem[a];
        if (stuckEn && (a == 9'h010)) w = w | 16'h0008;
        return w;
    endfunction

    // Address register then output register: data appears two cycles after the request.
    always @(posedge clk) begin
        if (bus.weA) mem[bus.addrA] <= bus.dinA;
        if (bus.weB) mem[bus.addrB] <= bus.dinB;
        rValA  <= bus.reA;
        rValB  <= bus.reB;
        rAddrA <= bus.addrA;
        rAddrB <= bus.addrB;
        if (rValA) bus.doutA <= readWord(rAddrA);
        if (rValB) bus.doutB <= readWord(rAddrB);
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ((bus.weA && bus.reA) || (bus.weB && bus.reB)) monViol++;
            if ((bus.weA || bus.reA || bus.weB || bus.reB) && (bus.addrA == bus.addrB)) monViol++;
        end
        if (bus.done === 1'b1) donePulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s);
        bus.start = 1'b1;
        bus.seed  = s;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic runToDone(input string tag, input int startCyc);
        int cyc;
        cyc = startCyc;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_doneCycle"}, 32'(cyc), 32'd771);
    endtask

    initial begin
        int cyc;
        int d0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.seed  = '0;
        tick();
        tick();
        checkOutput("rst_busy",   32'(bus.busy),    32'd0);
        checkOutput("rst_done",   32'(bus.done),    32'd0);
        checkOutput("rst_pass",   32'(bus.pass),    32'd0);
        checkOutput("rst_err",    32'(bus.err_cnt), 32'd0);
        checkOutput("rst_en",     32'({bus.weA, bus.weB, bus.reA, bus.reB}), 32'd0);
        checkOutput("rst_addrA",  32'(bus.addrA),   32'd0);
        checkOutput("rst_dinB",   32'(bus.dinB),    32'd0);
        rst = 1'b0;
        tick();

        // Clean RAM, zero seed.
        applyStimulus(16'h0000);
        checkOutput("s0_busy", 32'(bus.busy), 32'd1);
        runToDone("s0", 1);
        checkOutput("s0_pass", 32'(bus.pass),    32'd1);
        checkOutput("s0_err",  32'(bus.err_cnt), 32'd0);
        checkOutput("s0_busyAtDone", 32'(bus.busy), 32'd0);
        tick();

        // Seed 0xA5A5: spot-check write and crossed-read bus values.
        applyStimulus(16'hA5A5);
        repeat (5) tick();
        checkOutput("wr_en",    32'({bus.weA, bus.weB, bus.reA, bus.reB}), 32'hC);
        checkOutput("wr_addrA", 32'(bus.addrA), 32'h005);
        checkOutput("wr_dinA",  32'(bus.dinA),  32'hA5A0);
        checkOutput("wr_addrB", 32'(bus.addrB), 32'h105);
        checkOutput("wr_dinB",  32'(bus.dinB),  32'hA4A0);
        repeat (512) tick();
        checkOutput("xr_en",    32'({bus.weA, bus.weB, bus.reA, bus.reB}), 32'h3);
        checkOutput("xr_addrA", 32'(bus.addrA), 32'h105);
        checkOutput("xr_addrB", 32'(bus.addrB), 32'h005);
        runToDone("a5", 518);
        checkOutput("a5_pass",   32'(bus.pass), 32'd1);
        checkOutput("a5_mem005", 32'(mem[9'h005]), 32'hA5A0);
        checkOutput("a5_mem105", 32'(mem[9'h105]), 32'hA4A0);
        tick();
        checkOutput("a5_donePulse", 32'(bus.done), 32'd0);
        checkOutput("a5_passHeld",  32'(bus.pass), 32'd1);

        // Bit 3 of word 0x010 stuck at 1.
        stuckEn = 1'b1;
        applyStimulus(16'h0000);
        runToDone("sa", 1);
        checkOutput("sa_err",      32'(bus.err_cnt),   32'd2);
        checkOutput("sa_failAddr", 32'(bus.fail_addr), 32'h010);
        checkOutput("sa_failPort", 32'(bus.fail_port), 32'd0);
        checkOutput("sa_pass",     32'(bus.pass),      32'd0);
        repeat (3) tick();
        checkOutput("sa_errHeld",  32'(bus.err_cnt),   32'd2);
        checkOutput("sa_passHeld", 32'(bus.pass),      32'd0);
        stuckEn = 1'b0;

        // Reset in the middle of READ, then a fresh run.
        applyStimulus(16'h1234);
        repeat (299) tick();
        checkOutput("mid_inRead", 32'({bus.weA, bus.reA}), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_busy",  32'(bus.busy), 32'd0);
        checkOutput("mid_en",    32'({bus.weA, bus.weB, bus.reA, bus.reB}), 32'd0);
        checkOutput("mid_addrB", 32'(bus.addrB), 32'd0);
        checkOutput("mid_err",   32'(bus.err_cnt), 32'd0);
        tick();
        applyStimulus(16'h0F0F);
        runToDone("rr", 1);
        checkOutput("rr_pass", 32'(bus.pass), 32'd1);
        tick();

        // Start pulsed repeatedly while busy must not restart or extend the run.
        d0 = donePulses;
        applyStimulus(16'h5A5A);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            bus.start = (cyc % 37 == 0);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        checkOutput("rs_doneCycle", 32'(cyc), 32'd771);
        checkOutput("rs_pass",      32'(bus.pass), 32'd1);
        repeat (10) tick();
        checkOutput("rs_donePulses", 32'(donePulses - d0), 32'd1);
        checkOutput("rs_idle",       32'(bus.busy), 32'd0);

        checkOutput("bus_monitor", 32'(monViol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ram_tdp_bist_ctrl.md
RAM_TDP_BIST_CTRL -- requirements
Module: ram_tdp_bist_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 9, meaning RAM address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning RAM data width.
REQ-003 The block SHALL have parameter READ_LAT, default 2, meaning cycles from re/addr sampled to dout valid (address register plus output register).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, meaning begin one test run (sampled in IDLE only).
REQ-007 The block SHALL have port seed, input, DW, meaning pattern seed, captured on accepted start.
REQ-008 The block SHALL have ports weA/weB, output, 1, meaning port A/B write enable.
REQ-009 The block SHALL have ports reA/reB, output, 1, meaning port A/B read enable.
REQ-010 The block SHALL have ports addrA/addrB, output, AW, meaning port A/B address.
REQ-011 The block SHALL have ports dinA/dinB, output, DW, meaning port A/B write data.
REQ-012 The block SHALL have ports doutA/doutB, input, DW, meaning port A/B read data from the RAM.
REQ-013 The block SHALL have port busy, output, 1, meaning high from the cycle after accepted start through DRAIN.
REQ-014 The block SHALL have port done, output, 1, meaning one-cycle pulse at run end.
REQ-015 The block SHALL have port pass, output, 1, meaning valid with done and held until next accepted start; 1 means err_cnt==0.
REQ-016 The block SHALL have port err_cnt, output, 11, meaning number of mismatching reads this run (max 1024).
REQ-017 The block SHALL have port fail_addr, output, AW, meaning address of the first mismatch.
REQ-018 The block SHALL have port fail_port, output, 1, meaning port of the first mismatch (0=A, 1=B).

Function
REQ-019 The block SHALL use states IDLE, WRITE, READ, XREAD, DRAIN and DONE, with a shared 8-bit counter c cleared on each state entry.
REQ-020 The block SHALL use pattern P(x) = seed_q XOR zero-extended x for write data and expected data.
REQ-021 In IDLE, start=1 SHALL capture seed, clear err_cnt/fail_addr/fail_port/pass and move to WRITE; start in any other state SHALL be ignored.
REQ-022 WRITE (256 cycles) SHALL drive weA=weB=1, addrA=c, addrB=256+c, dinA=P(addrA), dinB=P(addrB).
REQ-023 READ (256 cycles) SHALL drive reA=reB=1, addrA=c, addrB=256+c.
REQ-024 XREAD (256 cycles) SHALL drive reA=reB=1, addrA=256+c, addrB=c.
REQ-025 DRAIN SHALL last READ_LAT cycles with all enables 0, then DONE SHALL last 1 cycle (done=1) and return to IDLE.
REQ-026 Outside WRITE, we SHALL be 0; outside READ/XREAD, re SHALL be 0; we and re SHALL never both be 1 on one port; addrA != addrB whenever any enable is high.
REQ-027 Each read SHALL carry {valid, addr, P(addr)} through a READ_LAT-deep pipe; at pipe exit, dout != expected (X/Z counted as mismatch) SHALL increment err_cnt.
REQ-028 If both ports mismatch in one cycle, err_cnt SHALL increase by 2.
REQ-029 fail_addr/fail_port SHALL capture only the first mismatch, with port A taking priority in the same cycle.
REQ-030 The block SHALL make done true 1 + 768 + READ_LAT cycles after the start-accept edge (771 for READ_LAT=2).
REQ-031 When idle, the block SHALL drive addr/din to 0.

Reset
REQ-032 rst SHALL force IDLE, clear the pipe, and drive all outputs to 0 on the next edge, including mid-run; RAM contents are not modified.
REQ-033 rst SHALL take priority over start in the same cycle.

Structure
REQ-034 Package ram_tdp_bist_pkg SHALL hold the state enum, default AW/DW/READ_LAT constants and the pattern function P.
REQ-035 Sub-module rd_check_pipe (valid/addr/expected delay line plus compare) SHALL be instantiated once per port.

Verification
REQ-036 Reset, then seed=0x0000 with a clean true-DP RAM model (READ_LAT=2) -> done at cycle 771, pass=1, err_cnt=0.
REQ-037 seed=0xA5A5 -> address 0x005 written 0xA5A0 and 0x105 written 0xA4A0 -> pass=1.
REQ-038 Bit 3 of RAM word 0x010 stuck-at-1, seed=0 -> err_cnt=2 (A in READ, B in XREAD), fail_addr=0x010, fail_port=0, pass=0.
REQ-039 rst asserted at cycle 300 (READ) -> next cycle busy=0 and all enables 0; a new start then completes with pass=1.
REQ-040 start pulsed repeatedly while busy -> exactly one done pulse, run length unchanged.
REQ-041 Bus monitor over the whole run -> no cycle with we&re on a port, and no cycle with addrA==addrB while enabled.
